// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - LC3 data-memory access op and state encodings
package lc3_mem_pkg;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_STI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IND_RD  = 2'd1,
        ST_DATA_RD = 2'd2,
        ST_DATA_WR = 2'd3
    } mem_state_t;

    // Final data phase of an op: bit 1 selects store, bit 0 (indirect) only adds a pointer read.
    function automatic mem_state_t data_state(input logic [1:0] op);
        return op[1] ? ST_DATA_WR : ST_DATA_RD;
    endfunction

endpackage

// File: rtl/lc3_mem_timeout.sv
// rtl/lc3_mem_timeout.sv - per-phase wait-state counter with expiry flag
module lc3_mem_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] count;

            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    count <= '0;
                end else if (inc) begin
                    count <= count + 1'b1;
                end
            end

            // Only a waiting cycle can expire, so a completion on the last cycle wins.
            assign expired = inc && (count == LAST);
        end else begin : g_off
            logic unused_tie;
            assign unused_tie = ^{clock, reset, clear, inc};
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lc3_mem_access_fsm.sv
// rtl/lc3_mem_access_fsm.sv - sequenced LC3 data-memory stage (LD/LDR, LDI, ST/STR, STI)
module lc3_mem_access_fsm
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mem_op,
    input  logic [ADDR_W-1:0] M_Addr,
    input  logic [DATA_W-1:0] M_Data,
    output logic [ADDR_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              Data_en,
    input  logic [DATA_W-1:0] Data_dout,
    input  logic              complete_data,
    output logic [DATA_W-1:0] memout,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_error
);

    mem_state_t        state;
    mem_state_t        state_next;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              access;
    logic              expired;

    assign access = (state != ST_IDLE);

    lc3_mem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (!access || complete_data),
        .inc    (access && !complete_data),
        .expired(expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = mem_op[0] ? ST_IND_RD : data_state(mem_op);
                end
            end
            ST_IND_RD: begin
                if (complete_data) begin
                    state_next = data_state(op_q);
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (complete_data || expired) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Memory-side request decoded straight from state so it tracks the FSM with no added latency.
    always_comb begin
        Data_en   = access;
        Data_rd   = (state != ST_DATA_WR);
        Data_addr = access ? addr_q : '0;
        Data_din  = (state == ST_DATA_WR) ? data_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= OP_LD;
            addr_q    <= '0;
            data_q    <= '0;
            memout    <= '0;
            mem_busy  <= 1'b0;
            mem_done  <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            mem_busy <= (state_next != ST_IDLE);
            mem_done <= access && (state_next == ST_IDLE);
            if (state == ST_IDLE && start) begin
                op_q      <= mem_op;
                addr_q    <= M_Addr;
                data_q    <= M_Data;
                mem_error <= 1'b0;
            end
            if (state == ST_IND_RD && complete_data) begin
                addr_q <= Data_dout[ADDR_W-1:0];
            end
            if (state == ST_DATA_RD && complete_data) begin
                memout <= Data_dout;
            end
            if (expired) begin
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_access_fsm.sv
// tb/tb_lc3_mem_access_fsm.sv - scoreboard bench for lc3_mem_access_fsm
module tb_lc3_mem_access_fsm;
    import lc3_mem_pkg::*;

    localparam int TMO = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic [15:0] din;
    } phase_t;

    typedef struct packed {
        logic [15:0] memout;
        logic        err;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mem_op = 2'b00;
    logic [15:0] M_Addr = 16'h0;
    logic [15:0] M_Data = 16'h0;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        Data_en;
    logic [15:0] Data_dout = 16'h0;
    logic        complete_data = 1'b0;
    logic [15:0] memout;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_error;

    lc3_mem_access_fsm #(
        .DATA_W(16),
        .ADDR_W(16),
        .TIMEOUT(TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .mem_op       (mem_op),
        .M_Addr       (M_Addr),
        .M_Data       (M_Data),
        .Data_addr    (Data_addr),
        .Data_din     (Data_din),
        .Data_rd      (Data_rd),
        .Data_en      (Data_en),
        .Data_dout    (Data_dout),
        .complete_data(complete_data),
        .memout       (memout),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_error    (mem_error)
    );

    always #5 clock = ~clock;

    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          end_cyc  = -10;
    int          done_cnt = 0;
    phase_t      exp_phase_q [$];
    res_t        exp_res_q [$];
    int          wait_q [$];
    logic [15:0] exp_memout = 16'h0;
    logic        exp_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_en", 32'(Data_en), 0);
        chk("rst_rd", 32'(Data_rd), 1);
        chk("rst_addr", 32'(Data_addr), 0);
        chk("rst_din", 32'(Data_din), 0);
        chk("rst_memout", 32'(memout), 0);
        chk("rst_busy", 32'(mem_busy), 0);
        chk("rst_done", 32'(mem_done), 0);
        chk("rst_err", 32'(mem_error), 0);
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 11) return int'($urandom_range(0, 3));
        if (r < 13) return TMO - 1;
        return TMO + int'($urandom_range(0, 3));
    endfunction

    // Reference: pointer read then data access, plain memory array semantics.
    task automatic run_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                          input int w0, input int w1);
        int          start_cnt;
        int          wd;
        bit          err;
        logic [15:0] a;
        phase_t      ph;
        res_t        rs;
        chk("err_held", 32'(mem_error), 32'(exp_err));
        chk("idle_busy", 32'(mem_busy), 0);
        err = 1'b0;
        a   = addr;
        wd  = w0;
        if (op[0]) begin
            wait_q.push_back(w0);
            if (w0 >= TMO) begin
                err = 1'b1;
            end else begin
                ph.addr = a; ph.rd = 1'b1; ph.din = 16'h0;
                exp_phase_q.push_back(ph);
                a  = ref_mem[a];
                wd = w1;
            end
        end
        if (!err) begin
            wait_q.push_back(wd);
            if (wd >= TMO) begin
                err = 1'b1;
            end else begin
                ph.addr = a; ph.rd = ~op[1]; ph.din = op[1] ? data : 16'h0;
                exp_phase_q.push_back(ph);
                if (op[1]) ref_mem[a] = data;
                else exp_memout = ref_mem[a];
            end
        end
        exp_err   = err;
        rs.memout = exp_memout;
        rs.err    = err;
        exp_res_q.push_back(rs);
        start_cnt = done_cnt;
        start  = 1'b1;
        mem_op = op;
        M_Addr = addr;
        M_Data = data;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", 32'(mem_busy), 1);
        chk("en_after_start", 32'(Data_en), 1);
        chk("err_cleared", 32'(mem_error), 0);
        for (int i = 0; i < 100 && done_cnt == start_cnt; i++) begin
            @(negedge clock);
            if (mem_busy && $urandom_range(0, 2) == 0) begin
                start  = 1'b1;
                mem_op = 2'($urandom_range(0, 3));
                M_Addr = 16'($urandom);
                M_Data = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_cnt == start_cnt) begin
            chk("done_seen", 0, 1);
            exp_res_q.delete();
            exp_phase_q.delete();
            wait_q.delete();
        end else begin
            chk("en_idle", 32'(Data_en), 0);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    res_t mon_r;
    initial forever begin
        @(posedge clock);
        #1;
        if (!reset && mem_done) begin
            if (exp_res_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_r = exp_res_q.pop_front();
                chk("memout", 32'(memout), 32'(mon_r.memout));
                chk("mem_error", 32'(mem_error), 32'(mon_r.err));
                chk("busy_at_done", 32'(mem_busy), 0);
                chk("done_latency", cyc, end_cyc + 1);
            end
            done_cnt++;
        end
    end

    // Memory model: one handshake per phase after the queued number of wait cycles.
    int     w_left  = 0;
    int     pcycles = 0;
    bit     active  = 1'b0;
    phase_t rsp_ph;
    initial forever begin
        @(negedge clock);
        if (reset || !Data_en) begin
            active        = 1'b0;
            complete_data = ($urandom_range(0, 3) == 0);
            Data_dout     = 16'($urandom);
        end else begin
            if (!active) begin
                active  = 1'b1;
                pcycles = 0;
                w_left  = (wait_q.size() != 0) ? wait_q.pop_front() : 1000;
            end
            pcycles++;
            if (w_left == 0) begin
                complete_data = 1'b1;
                if (exp_phase_q.size() == 0) begin
                    chk("unexpected_phase", 1, 0);
                end else begin
                    rsp_ph = exp_phase_q.pop_front();
                    chk("phase_addr", 32'(Data_addr), 32'(rsp_ph.addr));
                    chk("phase_rd", 32'(Data_rd), 32'(rsp_ph.rd));
                    chk("phase_din", 32'(Data_din), 32'(rsp_ph.din));
                end
                Data_dout = env_mem[Data_addr];
                if (!Data_rd) env_mem[Data_addr] = Data_din;
                active  = 1'b0;
                end_cyc = cyc;
            end else begin
                complete_data = 1'b0;
                Data_dout     = 16'($urandom);
                w_left--;
                if (pcycles == TMO) end_cyc = cyc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 16'($urandom);
            ref_mem[i] = env_mem[i];
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_reset_vals();
        reset = 1'b0;

        set_mem(16'h3000, 16'hBEEF);
        run_op(OP_LD, 16'h3000, 16'h0, 2, 0);
        set_mem(16'h3010, 16'h4000);
        set_mem(16'h4000, 16'h1234);
        run_op(OP_LDI, 16'h3010, 16'h0, 1, 3);
        set_mem(16'h3020, 16'h5000);
        run_op(OP_STI, 16'h3020, 16'hA5A5, 0, 2);
        chk("sti_write", 32'(env_mem[16'h5000]), 32'hA5A5);
        run_op(OP_LD, 16'h3000, 16'h0, TMO, 0);
        run_op(OP_LD, 16'h3000, 16'h0, TMO - 1, 0);
        run_op(OP_ST, 16'h3040, 16'h7777, 3, 0);
        run_op(OP_LDI, 16'h3010, 16'h0, 0, TMO + 2);

        set_mem(16'h3030, 16'h6000);
        wait_q.push_back(50);
        start  = 1'b1;
        mem_op = OP_LDI;
        M_Addr = 16'h3030;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("ind_en", 32'(Data_en), 1);
        chk("ind_rd", 32'(Data_rd), 1);
        chk("ind_addr", 32'(Data_addr), 32'h3030);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals();
        wait_q.delete();
        exp_memout = 16'h0;
        exp_err    = 1'b0;
        reset      = 1'b0;
        repeat (6) @(negedge clock);

        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), pick_wait(), pick_wait());
        end
        repeat (4) @(negedge clock);
        chk("leftover_results", exp_res_q.size(), 0);
        chk("leftover_phases", exp_phase_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
